// File: rtl/fib_job_runner.sv
`default_nettype none
// fib_job_runner: queues (n, a, b) jobs for the fib core, launches them one at a
// time and returns each result with its n and run length on a valid/ready port.
module fib_job_runner #(
  parameter int DEPTH = 4,
  parameter int N_W   = 6,
  parameter int D_W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           job_valid,
  output logic           job_ready,
  input  logic [N_W-1:0] job_n,
  input  logic [D_W-1:0] job_a,
  input  logic [D_W-1:0] job_b,
  output logic           core_r_enable,
  output logic           core_controlArr,
  output logic [N_W-1:0] core_init_n,
  output logic [D_W-1:0] core_init_a,
  output logic [D_W-1:0] core_init_b,
  input  logic           core_w_enable,
  input  logic [D_W-1:0] core_result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [D_W-1:0] res_value,
  output logic [N_W-1:0] res_n,
  output logic [31:0]    res_cycles
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam int             ENT_W   = N_W + 2 * D_W;
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [ENT_W-1:0] fifo_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             r_enable_q, r_enable_d;
  logic [N_W-1:0]   init_n_q, init_n_d;
  logic [D_W-1:0]   init_a_q, init_a_d;
  logic [D_W-1:0]   init_b_q, init_b_d;
  logic             wen_prev_q, wen_prev_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [D_W-1:0]   res_value_q, res_value_d;
  logic [N_W-1:0]   res_n_q, res_n_d;
  logic [31:0]      res_cycles_q, res_cycles_d;

  logic             empty;
  logic             full;
  logic             push;
  logic             wen_rise;
  logic [31:0]      cnt_inc;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push     = job_valid && !full;
  assign wen_rise = core_w_enable && !wen_prev_q;
  assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = {job_n, job_a, job_b};
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    r_enable_d   = 1'b0;
    init_n_d     = init_n_q;
    init_a_d     = init_a_q;
    init_b_d     = init_b_q;
    wen_prev_d   = core_w_enable;
    cnt_d        = cnt_q;
    res_valid_d  = res_valid_q;
    res_value_d  = res_value_q;
    res_n_d      = res_n_q;
    res_cycles_d = res_cycles_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          rd_ptr_d                       = rd_ptr_q + PTR_ONE;
          {init_n_d, init_a_d, init_b_d} = fifo_q[rd_ptr_q[PTR_W-1:0]];
          r_enable_d                     = 1'b1;
          state_d                        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // The edge-detect cycle itself is included in the reported run length.
        if (wen_rise) begin
          res_value_d  = core_result;
          res_cycles_d = cnt_inc;
          res_n_d      = init_n_q;
          res_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      r_enable_q   <= 1'b0;
      init_n_q     <= '0;
      init_a_q     <= '0;
      init_b_q     <= '0;
      wen_prev_q   <= 1'b0;
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_value_q  <= '0;
      res_n_q      <= '0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      r_enable_q   <= r_enable_d;
      init_n_q     <= init_n_d;
      init_a_q     <= init_a_d;
      init_b_q     <= init_b_d;
      wen_prev_q   <= wen_prev_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_value_q  <= res_value_d;
      res_n_q      <= res_n_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign job_ready       = !full;
  assign core_r_enable   = r_enable_q;
  assign core_controlArr = 1'b0;
  assign core_init_n     = init_n_q;
  assign core_init_a     = init_a_q;
  assign core_init_b     = init_b_q;
  assign res_valid       = res_valid_q;
  assign res_value       = res_value_q;
  assign res_n           = res_n_q;
  assign res_cycles      = res_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_job_runner.sv
`default_nettype none
// Bench for fib_job_runner: behavioural fib core model, scoreboard monitor,
// directed scenarios and a randomized job/consumer run.
module tb_fib_job_runner;

  localparam int DEPTH = 4;
  localparam int N_W   = 6;
  localparam int D_W   = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           job_valid = 1'b0;
  logic           job_ready;
  logic [N_W-1:0] job_n = '0;
  logic [D_W-1:0] job_a = '0;
  logic [D_W-1:0] job_b = '0;
  logic           core_r_enable;
  logic           core_controlArr;
  logic [N_W-1:0] core_init_n;
  logic [D_W-1:0] core_init_a;
  logic [D_W-1:0] core_init_b;
  logic           core_w_enable;
  logic [D_W-1:0] core_result;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [D_W-1:0] res_value;
  logic [N_W-1:0] res_n;
  logic [31:0]    res_cycles;

  fib_job_runner #(.DEPTH(DEPTH), .N_W(N_W), .D_W(D_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_n(job_n), .job_a(job_a), .job_b(job_b),
    .core_r_enable(core_r_enable), .core_controlArr(core_controlArr),
    .core_init_n(core_init_n), .core_init_a(core_init_a), .core_init_b(core_init_b),
    .core_w_enable(core_w_enable), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_n(res_n), .res_cycles(res_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Fib recurrence: n steps of (x, y) <- (x + y, x), result is y.
  function automatic logic [D_W-1:0] fib_ref(input int n, input logic [D_W-1:0] a,
                                             input logic [D_W-1:0] b);
    logic [D_W-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      y = x;
      x = t;
    end
    return y;
  endfunction

  // Cycle-stepping core model; wen_force 1/2 overrides w_enable high/low.
  logic           m_wen, m_busy;
  logic [D_W-1:0] m_cur, m_prev;
  logic [N_W-1:0] m_left;
  int             wen_force = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wen <= 1'b0; m_busy <= 1'b0; m_cur <= '0; m_prev <= '0; m_left <= '0;
    end else if (core_r_enable) begin
      m_wen <= 1'b0; m_busy <= 1'b1;
      m_cur <= core_init_a; m_prev <= core_init_b; m_left <= core_init_n;
    end else if (m_busy) begin
      if (m_left == '0) begin
        m_wen <= 1'b1; m_busy <= 1'b0;
      end else begin
        m_cur <= m_cur + m_prev; m_prev <= m_cur; m_left <= m_left - 1'b1;
      end
    end
  end

  assign core_w_enable = (wen_force == 1) ? 1'b1 : (wen_force == 2) ? 1'b0 : m_wen;
  assign core_result   = m_prev;

  // Monitor / scoreboard, sampling at the falling edge.
  typedef struct packed {
    logic [N_W-1:0] n;
    logic [D_W-1:0] a;
    logic [D_W-1:0] b;
  } job_t;

  job_t           exp_q[$];
  job_t           cur_job;
  logic [D_W-1:0] res_log[$];
  int             cyc = 0;
  int             launch_cyc = -1, accept_cyc = -1, push_cyc = -1, edge_cyc = -1;
  int             n_launch = 0, n_accept = 0;
  bit             in_run = 0, have_exp = 0, prev_ren = 0, prev_wen = 0;
  logic [D_W-1:0] exp_value;
  logic [N_W-1:0] exp_n;
  logic [31:0]    exp_cycles;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      in_run = 0; have_exp = 0; prev_ren = 0; prev_wen = 0; edge_cyc = -1;
    end else begin
      if (prev_ren) check("ren_width", core_r_enable, 0);
      if (core_r_enable) begin
        if (exp_q.size() == 0) begin
          check("launch_without_job", 1, 0);
        end else begin
          cur_job = exp_q.pop_front();
          check("init_n", core_init_n, cur_job.n);
          check("init_a", core_init_a, cur_job.a);
          check("init_b", core_init_b, cur_job.b);
        end
        launch_cyc = cyc; n_launch++; in_run = 1;
      end
      if (in_run && cyc > launch_cyc && core_w_enable && !prev_wen) begin
        in_run     = 0;
        have_exp   = 1;
        edge_cyc   = cyc;
        exp_value  = fib_ref(int'(cur_job.n), cur_job.a, cur_job.b);
        exp_n      = cur_job.n;
        exp_cycles = cyc - launch_cyc;
        check("valid_early", res_valid, 0);
      end
      if (edge_cyc >= 0 && cyc == edge_cyc + 1) check("valid_rise", res_valid, 1);
      check("res_unexpected", res_valid & ~have_exp, 0);
      if (res_valid && have_exp) begin
        check("res_value", res_value, exp_value);
        check("res_n", res_n, exp_n);
        check("res_cycles", res_cycles, exp_cycles);
        check("launch_in_hold", core_r_enable, 0);
      end
      if (res_valid && res_ready) begin
        have_exp = 0; n_accept++; accept_cyc = cyc;
        res_log.push_back(res_value);
      end
      if (job_valid && job_ready) begin
        exp_q.push_back('{n: job_n, a: job_a, b: job_b});
        push_cyc = cyc;
      end
      prev_ren = core_r_enable;
      prev_wen = core_w_enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [N_W-1:0] n, input logic [D_W-1:0] a,
                          input logic [D_W-1:0] b);
    bit done;
    done = 0;
    job_valid = 1'b1; job_n = n; job_a = a; job_b = b;
    for (int i = 0; i < 400 && !done; i++) begin
      if (job_ready) done = 1;
      tick();
    end
    job_valid = 1'b0;
    check("push_accepted", done, 1);
  endtask

  task automatic wait_accepts(input int target);
    for (int i = 0; i < 3000 && n_accept < target; i++) tick();
    check("accept_in_time", n_accept >= target, 1);
  endtask

  task automatic wait_launches(input int target);
    for (int i = 0; i < 400 && n_launch < target; i++) tick();
    check("launch_in_time", n_launch >= target, 1);
  endtask

  task automatic wait_res_valid();
    for (int i = 0; i < 400 && !res_valid; i++) tick();
    check("res_valid_in_time", res_valid, 1);
  endtask

  initial begin
    int base, nl, na, total;

    // Reset values
    repeat (3) tick();
    check("rst_ren", core_r_enable, 0);
    check("rst_ctrl", core_controlArr, 0);
    check("rst_init_n", core_init_n, 0);
    check("rst_init_a", core_init_a, 0);
    check("rst_valid", res_valid, 0);
    check("rst_value", res_value, 0);
    check("rst_cycles", res_cycles, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", job_ready, 1);

    // Single job: push-to-launch latency and result
    res_ready = 1'b1;
    push_job(6'd10, 32'd1, 32'd0);
    wait_accepts(1);
    check("push_to_launch", launch_cyc, push_cyc + 2);
    check("fib10_value", res_log[res_log.size()-1], 55);

    // Queue n=1,2,10,40 plus one more while the consumer stalls: FIFO fills
    res_ready = 1'b0;
    base = res_log.size();
    push_job(6'd1, 32'd1, 32'd0);
    push_job(6'd2, 32'd1, 32'd0);
    push_job(6'd10, 32'd1, 32'd0);
    push_job(6'd40, 32'd1, 32'd0);
    push_job(6'd5, 32'd3, 32'd7);
    tick();
    check("ready_low_when_full", job_ready, 0);
    res_ready = 1'b1;
    wait_accepts(n_accept + 5);
    check("order_n1", res_log[base], 1);
    check("order_n2", res_log[base+1], 1);
    check("order_n10", res_log[base+2], 55);
    check("ready_after_drain", job_ready, 1);

    // Stall the consumer 20 cycles on n=10: outputs stable, no launch
    res_ready = 1'b0;
    push_job(6'd10, 32'd1, 32'd0);
    push_job(6'd3, 32'd2, 32'd5);
    wait_res_valid();
    nl = n_launch;
    repeat (20) tick();
    check("no_launch_while_held", n_launch, nl);
    check("held_value", res_value, 55);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_launches(nl + 1);
    check("accept_to_launch", launch_cyc, accept_cyc + 2);
    res_ready = 1'b1;
    wait_accepts(n_accept + 1);

    // w_enable stuck high across the launch: only a fresh 0->1 completes
    na = n_accept;
    wen_force = 1;
    push_job(6'd3, 32'd1, 32'd1);
    repeat (30) tick();
    check("stuck_no_result", res_valid, 0);
    check("stuck_no_accept", n_accept, na);
    wen_force = 2;
    tick();
    wen_force = 0;
    wait_accepts(na + 1);

    // Push and pop in the same cycle keep occupancy unchanged
    res_ready = 1'b0;
    push_job(6'd2, 32'd1, 32'd0);
    push_job(6'd4, 32'd1, 32'd0);
    push_job(6'd6, 32'd1, 32'd0);
    push_job(6'd8, 32'd1, 32'd0);
    wait_res_valid();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    job_valid = 1'b1; job_n = 6'd9; job_a = 32'd2; job_b = 32'd1;
    check("ready_at_pop", job_ready, 1);
    tick();
    job_valid = 1'b0;
    check("ready_after_pushpop", job_ready, 1);
    job_valid = 1'b1; job_n = 6'd7; job_a = 32'd1; job_b = 32'd0;
    tick();
    job_valid = 1'b0;
    check("full_after_refill", job_ready, 0);
    check("pushpop_launch", launch_cyc, accept_cyc + 2);
    res_ready = 1'b1;
    wait_accepts(n_accept + 5);

    // Reset in WAIT aborts the job and clears every output
    nl = n_launch;
    push_job(6'd40, 32'd1, 32'd0);
    wait_launches(nl + 1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ren", core_r_enable, 0);
    check("mid_rst_init_n", core_init_n, 0);
    check("mid_rst_init_a", core_init_a, 0);
    check("mid_rst_init_b", core_init_b, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_value", res_value, 0);
    check("mid_rst_n", res_n, 0);
    check("mid_rst_cycles", res_cycles, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("ready_after_mid_rst", job_ready, 1);
    repeat (50) tick();
    check("aborted_no_result", res_valid, 0);

    // Randomized jobs against a randomly stalling consumer
    total = n_accept + 25;
    fork
      begin
        for (int j = 0; j < 25; j++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_job(N_W'($urandom_range(0, 24)), $urandom, $urandom);
        end
      end
      begin
        for (int i = 0; i < 4000 && n_accept < total; i++) begin
          res_ready = 1'($urandom_range(0, 1));
          tick();
        end
        res_ready = 1'b1;
      end
    join
    wait_accepts(total);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
